pager_alert: RTL and testbench

PAGER_ALERT -- requirements
Module: pager_alert

---
 rtl/pager_alert.sv | 177 +++++++++++++++++
 tb/tb_pager_alert.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pager_alert.sv
// pager_alert: pager buzzer sequencer.
// A rising edge on page_in starts a burst of beeps on buzzer; ack stops the
// alert at any time. An alert that runs to completion without ack sets the
// sticky missed flag. page_count tallies page_in rising edges and saturates.
// Optional feature macro: PAGER_ALERT_REPEAT_EN -- when defined, a completed
// burst is followed by a silent gap and another burst, up to MAX_BURSTS
// bursts; when undefined, the alert ends after the first burst.
module pager_alert #(
    parameter int BEEP_ON_CYC    = 4,
    parameter int BEEP_OFF_CYC   = 4,
    parameter int BEEP_COUNT     = 3,
    parameter int REPEAT_GAP_CYC = 16,
    parameter int MAX_BURSTS     = 2,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             page_in,
    input  logic             ack,
    output logic             buzzer,
    output logic             alert_active,
    output logic             missed,
    output logic [CNT_W-1:0] page_count
);

    // Timer sized for the longest interval, holding (length - 1) as its load.
    localparam int TMR_MAX_AB = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
    localparam int TMR_MAX    = (TMR_MAX_AB > REPEAT_GAP_CYC) ? TMR_MAX_AB : REPEAT_GAP_CYC;
    localparam int TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int BEEP_W     = (BEEP_COUNT > 1) ? $clog2(BEEP_COUNT + 1) : 1;
    localparam int BURST_W    = (MAX_BURSTS > 1) ? $clog2(MAX_BURSTS + 1) : 1;

`ifdef PAGER_ALERT_REPEAT_EN
    localparam int N_BURSTS = MAX_BURSTS;
`else
    localparam int N_BURSTS = 1;
`endif

    localparam logic [TMR_W-1:0]  ON_LOAD   = TMR_W'(BEEP_ON_CYC - 1);
    localparam logic [TMR_W-1:0]  OFF_LOAD  = TMR_W'(BEEP_OFF_CYC - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(REPEAT_GAP_CYC - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_COUNT);

    // state    | meaning
    // IDLE     | no alert in progress
    // BEEP_ON  | buzzer driven, timing one beep
    // BEEP_OFF | buzzer silent between beeps of a burst
    // GAP      | silent pause between bursts (repeat builds only)
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [BEEP_W-1:0]  beep_q, beep_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               missed_q, missed_d;
    logic               page_q;
    logic [CNT_W-1:0]   count_q;
    logic               buzzer_q, buzzer_d;
    logic               active_q, active_d;
    logic               page_rise;

    assign page_rise = page_in & ~page_q;

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            beep_q   <= '0;
            burst_q  <= '0;
            missed_q <= 1'b0;
            page_q   <= 1'b0;
            count_q  <= '0;
            buzzer_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            beep_q   <= beep_d;
            burst_q  <= burst_d;
            missed_q <= missed_d;
            page_q   <= page_in;
            if (page_rise && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + CNT_W'(1);
            end
            buzzer_q <= buzzer_d;
            active_q <= active_d;
        end
    end

    // Next-state: timer expiry drives the beep/burst sequence, ack overrides all.
    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q != '0) ? (timer_q - TMR_W'(1)) : timer_q;
        beep_d   = beep_q;
        burst_d  = burst_q;
        missed_d = missed_q;

        unique case (state_q)
            IDLE: begin
                if (ack) begin
                    missed_d = 1'b0;
                end
                if (page_rise) begin
                    state_d = BEEP_ON;
                    timer_d = ON_LOAD;
                    beep_d  = '0;
                    burst_d = '0;
                end
            end
            BEEP_ON: begin
                if (timer_q == '0) begin
                    state_d = BEEP_OFF;
                    timer_d = OFF_LOAD;
                    beep_d  = beep_q + BEEP_W'(1);
                end
            end
            BEEP_OFF: begin
                if (timer_q == '0) begin
                    if (beep_q < BEEP_LAST) begin
                        state_d = BEEP_ON;
                        timer_d = ON_LOAD;
                    end else begin
                        beep_d = '0;
                        if ((int'(burst_q) + 1) < N_BURSTS) begin
                            state_d = GAP;
                            timer_d = GAP_LOAD;
                            burst_d = burst_q + BURST_W'(1);
                        end else begin
                            // Ran out of bursts without an ack: give up and flag it.
                            state_d  = IDLE;
                            timer_d  = '0;
                            burst_d  = '0;
                            missed_d = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = BEEP_ON;
                    timer_d = ON_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Acknowledge wins over any timer transition in the same cycle.
        if (ack && (state_q != IDLE)) begin
            state_d  = IDLE;
            timer_d  = '0;
            beep_d   = '0;
            burst_d  = '0;
            missed_d = 1'b0;
        end
    end

    // Output decode from the next state so the outputs themselves are flops.
    always_comb begin
        buzzer_d = (state_d == BEEP_ON);
        active_d = (state_d != IDLE);
    end

    assign buzzer       = buzzer_q;
    assign alert_active = active_q;
    assign missed       = missed_q;
    assign page_count   = count_q;

endmodule

// File: tb/tb_pager_alert.sv
// Testbench for pager_alert (default parameters). Follows the
// PAGER_ALERT_REPEAT_EN macro so the same bench covers both builds.
module tb_pager_alert;

    localparam int ON    = 4;
    localparam int OFF   = 4;
    localparam int BC    = 3;
    localparam int GAPC  = 16;
    localparam int MB    = 2;
    localparam int CNT_W = 4;

`ifdef PAGER_ALERT_REPEAT_EN
    localparam bit REPEAT = 1'b1;
    localparam int END_J  = 65;
`else
    localparam bit REPEAT = 1'b0;
    localparam int END_J  = 25;
`endif

    localparam int BURST_LEN = BC * (ON + OFF);
    localparam int CYCLE_LEN = BURST_LEN + GAPC;
    localparam int TOTAL     = REPEAT ? (MB * BURST_LEN + (MB - 1) * GAPC) : BURST_LEN;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             page_in;
    logic             ack;
    logic             buzzer;
    logic             alert_active;
    logic             missed;
    logic [CNT_W-1:0] page_count;

    pager_alert #(
        .BEEP_ON_CYC    (ON),
        .BEEP_OFF_CYC   (OFF),
        .BEEP_COUNT     (BC),
        .REPEAT_GAP_CYC (GAPC),
        .MAX_BURSTS     (MB),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .page_in      (page_in),
        .ack          (ack),
        .buzzer       (buzzer),
        .alert_active (alert_active),
        .missed       (missed),
        .page_count   (page_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: alert timeline as elapsed cycles since the alert began.
    bit m_active;
    bit m_missed;
    bit m_prev;
    int m_k;
    int m_count;

    function automatic bit buzz_at(input int k);
        int pos;
        if (k < 0 || k >= TOTAL) return 1'b0;
        pos = REPEAT ? (k % CYCLE_LEN) : k;
        if (pos >= BURST_LEN) return 1'b0;
        return ((pos % (ON + OFF)) < ON);
    endfunction

    function automatic bit m_buzzer();
        return m_active && buzz_at(m_k);
    endfunction

    task automatic m_reset();
        m_active = 1'b0;
        m_missed = 1'b0;
        m_prev   = 1'b0;
        m_k      = 0;
        m_count  = 0;
    endtask

    task automatic m_step(input bit p, input bit a);
        bit edge_seen;
        edge_seen = p && !m_prev;
        m_prev    = p;
        if (edge_seen && m_count < CNT_MAX) m_count++;
        if (m_active) begin
            if (a) begin
                m_active = 1'b0;
                m_missed = 1'b0;
            end else begin
                m_k++;
                if (m_k == TOTAL) begin
                    m_active = 1'b0;
                    m_missed = 1'b1;
                end
            end
        end else begin
            if (a) m_missed = 1'b0;
            if (edge_seen) begin
                m_active = 1'b1;
                m_k      = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it in, advance the model, settle.
    task automatic cycle(input bit p, input bit a);
        page_in = p;
        ack     = a;
        @(posedge clk);
        m_step(p, a);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        page_in = 1'b0;
        ack     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        m_reset();
    endtask

    // Expected buzzer for the directed single-alert run, cycles after the edge.
    function automatic bit ref_buzz(input int j);
        bit b;
        b = (j >= 1 && j <= 4) || (j >= 9 && j <= 12) || (j >= 17 && j <= 20);
        if (REPEAT) b = b || (j >= 41 && j <= 44) || (j >= 49 && j <= 52) || (j >= 57 && j <= 60);
        return b;
    endfunction

    task automatic test_reset();
        rst     = 1'b1;
        page_in = 1'b1;
        ack     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_tests++;
        if ({buzzer, alert_active, missed} !== 3'b000 || page_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got buz=%b act=%b mis=%b cnt=%0d, want all 0",
                     buzzer, alert_active, missed, page_count);
        end
        #2;
        rst = 1'b0;
        m_reset();
        // page_in already high at release counts as an edge
        cycle(1'b1, 1'b0);
        n_tests++;
        if (page_count !== CNT_W'(1) || alert_active !== 1'b1 || buzzer !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_edge: got cnt=%0d act=%b buz=%b, want cnt=1 act=1 buz=1",
                     page_count, alert_active, buzzer);
        end
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_single_alert();
        apply_reset();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int j = 1; j <= END_J + 4; j++) begin
            n_tests++;
            if (buzzer !== ref_buzz(j) || alert_active !== (j < END_J) || missed !== (j >= END_J)) begin
                n_fail++;
                $display("FAIL single_alert N+%0d: got buz=%b act=%b mis=%b, want buz=%b act=%b mis=%b",
                         j, buzzer, alert_active, missed, ref_buzz(j), (j < END_J), (j >= END_J));
            end
            cycle(1'b1, 1'b0);
        end
        n_tests++;
        if (page_count !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL single_alert_count: got %0d want 1", page_count);
        end
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_ack();
        apply_reset();
        cycle(1'b1, 1'b0);
        for (int j = 2; j <= 10; j++) cycle(1'b0, 1'b0);
        n_tests++;
        if (buzzer !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_pre_buzzer N+10: got %b want 1", buzzer);
        end
        cycle(1'b0, 1'b1);
        n_tests++;
        if (buzzer !== 1'b0 || alert_active !== 1'b0 || missed !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_stop N+11: got buz=%b act=%b mis=%b, want 0 0 0",
                     buzzer, alert_active, missed);
        end
        for (int j = 0; j < 40; j++) begin
            cycle(1'b0, 1'b0);
            n_tests++;
            if (buzzer !== 1'b0 || alert_active !== 1'b0 || missed !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_quiet cycle %0d: got buz=%b act=%b mis=%b, want 0 0 0",
                         j, buzzer, alert_active, missed);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            for (int h = 0; h < 2; h++) begin
                cycle(h == 0, 1'b0);
                n_tests++;
                if (buzzer !== m_buzzer() || alert_active !== m_active) begin
                    n_fail++;
                    $display("FAIL sat_timing edge %0d: got buz=%b act=%b, want buz=%b act=%b",
                             i, buzzer, alert_active, m_buzzer(), m_active);
                end
            end
        end
        n_tests++;
        if (page_count !== CNT_W'(15)) begin
            n_fail++;
            $display("FAIL sat_count: got %0d want 15", page_count);
        end
        cycle(1'b1, 1'b0);
        n_tests++;
        if (page_count !== CNT_W'(15)) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d want 15", page_count);
        end
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cycle(1'b1, 1'b0);
        for (int j = 2; j <= 6; j++) cycle(1'b0, 1'b0);
        n_tests++;
        if (alert_active !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre N+6: got act=%b want 1", alert_active);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({buzzer, alert_active, missed} !== 3'b000 || page_count !== '0) begin
            n_fail++;
            $display("FAIL rstmid_immediate: got buz=%b act=%b mis=%b cnt=%0d, want all 0",
                     buzzer, alert_active, missed, page_count);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        m_reset();
        for (int j = 0; j < 40; j++) begin
            cycle(1'b0, 1'b0);
            n_tests++;
            if (buzzer !== 1'b0 || alert_active !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet cycle %0d: got buz=%b act=%b, want 0 0",
                         j, buzzer, alert_active);
            end
        end
    endtask

    task automatic test_ack_edge_idle();
        apply_reset();
        cycle(1'b1, 1'b0);
        for (int j = 0; j < TOTAL; j++) cycle(1'b0, 1'b0);
        n_tests++;
        if (missed !== 1'b1 || alert_active !== 1'b0) begin
            n_fail++;
            $display("FAIL ackedge_missed: got mis=%b act=%b, want mis=1 act=0", missed, alert_active);
        end
        cycle(1'b1, 1'b1);
        n_tests++;
        if (missed !== 1'b0 || alert_active !== 1'b1 || buzzer !== 1'b1) begin
            n_fail++;
            $display("FAIL ackedge_start: got mis=%b act=%b buz=%b, want 0 1 1",
                     missed, alert_active, buzzer);
        end
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            apply_reset();
            for (int i = 0; i < 500; i++) begin
                bit p;
                bit a;
                p = ($urandom_range(0, 9) < (s + 1));
                a = ($urandom_range(0, 59) == 0);
                cycle(p, a);
                n_tests++;
                if (buzzer !== m_buzzer() || alert_active !== m_active ||
                    missed !== m_missed || page_count !== CNT_W'(m_count)) begin
                    n_fail++;
                    $display("FAIL random seg %0d cycle %0d: got buz=%b act=%b mis=%b cnt=%0d, want buz=%b act=%b mis=%b cnt=%0d",
                             s, i, buzzer, alert_active, missed, page_count,
                             m_buzzer(), m_active, m_missed, m_count);
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        page_in = 1'b0;
        ack     = 1'b0;
        m_reset();
        test_reset();
        test_single_alert();
        test_ack();
        test_saturation();
        test_reset_mid();
        test_ack_edge_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
